// File: rtl/md_unit_gen.sv
// Multiply/divide unit for the EX stage: owns HI/LO, runs mult/div-class ops
// for a fixed per-class latency, and supports flush-abort and mthi/mtlo.
module md_unit_gen #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   shadow;
  logic                 shadow_wr;

  logic                 is_mul, is_div, is_signed_mul, accept;
  logic                 div_signed, div_by_zero;
  logic [2*WIDTH-1:0]   ext_a, ext_b, product, acc, mul_res, result;
  logic [WIDTH-1:0]     mag_a, mag_b, div_den, quo_mag, rem_mag, quo, rem;

  // Handshake: an op is taken on an edge where start=1, busy=0, flush=0 and
  // op is mult- or div-class; busy then holds until commit or flush.
  always_comb begin
    is_mul        = op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    is_div        = op inside {OP_DIV, OP_DIVU};
    is_signed_mul = op inside {OP_MULT, OP_MADD, OP_MSUB};
    accept        = start && !busy && !flush && (is_mul || is_div);

    ext_a   = is_signed_mul ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
    ext_b   = is_signed_mul ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
    product = ext_a * ext_b;
    acc     = {hi, lo};
    case (op)
      OP_MADD, OP_MADDU: mul_res = acc + product;
      OP_MSUB, OP_MSUBU: mul_res = acc - product;
      default:           mul_res = product;
    endcase

    // Signed divide on magnitudes; most-negative / -1 falls out naturally.
    div_signed  = (op == OP_DIV);
    mag_a       = (div_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    mag_b       = (div_signed && src_b[WIDTH-1]) ? -src_b : src_b;
    div_by_zero = (src_b == '0);
    div_den     = div_by_zero ? WIDTH'(1) : mag_b;
    quo_mag     = mag_a / div_den;
    rem_mag     = mag_a % div_den;
    quo         = (div_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1])) ? -quo_mag : quo_mag;
    rem         = (div_signed && src_a[WIDTH-1]) ? -rem_mag : rem_mag;

    result = is_div ? {rem, quo} : mul_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      shadow    <= '0;
      shadow_wr <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (flush) begin
          busy <= 1'b0;
          cnt  <= '0;
        end else if (cnt == CW'(1)) begin
          busy <= 1'b0;
          cnt  <= '0;
          done <= 1'b1;
          if (shadow_wr) begin
            hi <= shadow[2*WIDTH-1:WIDTH];
            lo <= shadow[WIDTH-1:0];
          end
        end else begin
          cnt <= cnt - CW'(1);
        end
      end else if (!flush) begin
        if (accept) begin
          shadow    <= result;
          shadow_wr <= !(is_div && div_by_zero);
          busy      <= 1'b1;
          cnt       <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        end else if (op == OP_MTHI) begin
          hi <= src_a;
        end else if (op == OP_MTLO) begin
          lo <= src_a;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_unit_gen.sv
// Bench for md_unit_gen: directed literal cases, then randomized traffic
// checked every cycle against a 64-bit arithmetic model of HI/LO.
module tb_md_unit_gen;

  logic        clk, reset;
  logic        start, flush;
  logic [3:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        s_start, s_flush;
  logic [3:0]  s_op;
  logic [15:0] s_a, s_b;
  logic        s_busy, s_done;
  logic [15:0] s_hi, s_lo;

  int n_checks = 0;
  int n_fail   = 0;

  md_unit_gen #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  md_unit_gen #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .op(s_op), .src_a(s_a), .src_b(s_b),
    .flush(s_flush), .busy(s_busy), .done(s_done), .hi(s_hi), .lo(s_lo)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model
  function automatic bit is_md(input logic [3:0] o);
    return o inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9};
  endfunction

  function automatic void model_compute(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] acc, output logic wr, output logic [63:0] res);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    p   = (o == 4'd0 || o == 4'd6 || o == 4'd8) ? sa * sb : ua * ub;
    wr  = 1'b1;
    res = '0;
    case (o)
      4'd0, 4'd1: res = p;
      4'd6, 4'd7: res = acc + p;
      4'd8, 4'd9: res = acc - p;
      4'd2: begin
        if (b == 0) begin wr = 1'b0; res = acc; end
        else begin sq = sa / sb; sr = sa % sb; res = {sr[31:0], sq[31:0]}; end
      end
      4'd3: begin
        if (b == 0) begin wr = 1'b0; res = acc; end
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
      default: res = acc;
    endcase
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_wr = 1'b0;
  logic [63:0] m_res = '0;
  int          m_rem = 0;
  logic [63:0] exp_q[$];

  // model update on each edge, then compare all outputs away from the edge
  always @(posedge clk) begin
    logic [63:0] e;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (flush) begin
          m_busy = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_back());
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            if (m_wr) {m_hi, m_lo} = m_res;
          end
        end
      end else if (!flush) begin
        if (start && is_md(op)) begin
          model_compute(op, src_a, src_b, {m_hi, m_lo}, m_wr, m_res);
          m_rem  = (op == 4'd2 || op == 4'd3) ? 10 : 5;
          m_busy = 1'b1;
          exp_q.push_back(m_wr ? m_res : {m_hi, m_lo});
        end else if (op == 4'd4) m_hi = src_a;
        else if (op == 4'd5) m_lo = src_a;
      end
    end
    #2;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (done) begin
      if (exp_q.size() == 0) chk("sb_unexpected_done", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_result", {hi, lo}, e);
      end
    end
  end

  // driver tasks
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int cyc);
    @(negedge clk); start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk); start = 1'b0; op = 4'd10;
    cyc = 0;
    while (busy && cyc < 100) begin cyc++; @(negedge clk); end
    if (cyc >= 100) chk("busy_timeout", 64'd1, 64'd0);
  endtask

  task automatic move_to(input logic [3:0] o, input logic [31:0] v);
    @(negedge clk); op = o; src_a = v;
    @(negedge clk); op = 4'd10;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    logic [3:0] valid_ops [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9};
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 4'd10; src_a = '0; src_b = '0;
    s_start = 1'b0; s_flush = 1'b0; s_op = 4'd10; s_a = '0; s_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'h0);
    chk("reset_busy_done", {busy, done}, 2'b00);
    chk("reset_small", {s_busy, s_done, s_hi, s_lo}, 34'h0);
    reset = 1'b0;

    run_op(4'd0, 32'hFFFF_FFFE, 32'd3, cyc);
    chk("mult_cycles", 64'(cyc), 64'd5);
    chk("mult_done", done, 1'b1);
    chk("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    @(negedge clk);
    chk("mult_done_pulse", done, 1'b0);

    run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    chk("multu_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    move_to(4'd4, 32'd0);
    move_to(4'd5, 32'd10);
    chk("mthi_mtlo", {hi, lo}, 64'd10);
    run_op(4'd6, 32'd3, 32'd4, cyc);
    chk("madd_res", {hi, lo}, 64'd22);
    run_op(4'd9, 32'd5, 32'd5, cyc);
    chk("msubu_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(4'd2, 32'hFFFF_FFF9, 32'd2, cyc);
    chk("div_cycles", 64'(cyc), 64'd10);
    chk("div_neg_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    chk("div_ovf_res", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(4'd3, 32'd1234, 32'd0, cyc);
    chk("divu0_cycles", 64'(cyc), 64'd10);
    chk("divu0_done", done, 1'b1);
    chk("divu0_res", {hi, lo}, 64'h0000_0000_8000_0000);

    // flush on busy cycle 4
    @(negedge clk); start = 1'b1; op = 4'd2; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk); start = 1'b0; op = 4'd10;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_busy_done", {busy, done}, 2'b00);
    chk("flush_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    repeat (12) @(negedge clk);
    chk("flush_no_late_done", {busy, done}, 2'b00);

    // start during busy is ignored
    @(negedge clk); start = 1'b1; op = 4'd2; src_a = 32'd50; src_b = 32'd6;
    @(negedge clk); op = 4'd0; src_a = 32'd3; src_b = 32'd3;
    @(negedge clk); start = 1'b0; op = 4'd10;
    cyc = 1;
    while (busy && cyc < 100) begin cyc++; @(negedge clk); end
    chk("ignored_start_cycles", 64'(cyc), 64'd10);
    chk("ignored_start_res", {hi, lo}, 64'h0000_0002_0000_0008);

    // narrow instance, single-cycle multiply
    @(negedge clk); s_start = 1'b1; s_op = 4'd0; s_a = 16'h8000; s_b = 16'h8000;
    @(negedge clk); s_start = 1'b0; s_op = 4'd10;
    chk("small_busy", {s_busy, s_done}, 2'b10);
    @(negedge clk);
    chk("small_mult_commit", {s_busy, s_done, s_hi, s_lo}, {2'b01, 16'h4000, 16'h0000});
    @(negedge clk); s_start = 1'b1; s_op = 4'd2; s_a = 16'hFFF9; s_b = 16'd2;
    @(negedge clk); s_start = 1'b0; s_op = 4'd10;
    repeat (3) @(negedge clk);
    chk("small_div", {s_done, s_hi, s_lo}, {1'b1, 16'hFFFF, 16'hFFFD});

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 149) == 0);
      flush = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 2) != 0);
      op    = ($urandom_range(0, 3) != 0) ? valid_ops[$urandom_range(0, 7)] : 4'($urandom_range(0, 15));
      src_a = pick_val();
      src_b = pick_val();
    end
    @(negedge clk); reset = 1'b0; flush = 1'b0; start = 1'b0; op = 4'd10;
    cyc = 0;
    while (busy && cyc < 100) begin cyc++; @(negedge clk); end

    // reset mid-divide
    move_to(4'd4, 32'h1234);
    @(negedge clk); start = 1'b1; op = 4'd3; src_a = 32'd99; src_b = 32'd9;
    @(negedge clk); start = 1'b0; op = 4'd10;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("reset_mid_div", {busy, done, hi, lo}, 66'h0);
    repeat (12) @(negedge clk);
    chk("reset_mid_div_quiet", {busy, done, hi, lo}, 66'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit_gen.md
Name: md_unit_gen

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS core; sits in the EX stage beside the ALU and owns the HI/LO registers.
- Generalises the fixed 32-bit MD block:
  - configurable operand width and per-class latency
  - adds madd/maddu/msub/msubu accumulate ops
  - adds a flush input that aborts an in-flight operation on exception or interrupt
  - adds a one-cycle done pulse
- The hazard unit stalls on busy; mfhi/mflo read the hi/lo outputs directly.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu; must be >= 1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be >= 1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request to launch a multi-cycle op (mult-class or div-class)
- op  input  4  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu, 8 msub, 9 msubu, 10-15 no-op
- src_a  input  WIDTH  rs operand
- src_b  input  WIDTH  rt operand
- flush  input  1  abort the in-flight op, discard its result
- busy  output  1  high while an op is in flight
- done  output  1  one-cycle pulse when a result commits to HI/LO
- hi  output  WIDTH  architectural HI
- lo  output  WIDTH  architectural LO

Behaviour:
- Reset (synchronous, any time, including mid-operation):
  - hi = 0, lo = 0, busy = 0, done = 0
  - internal counter and shadow result cleared
- Accept: on a clk edge with start=1, busy=0, flush=0, and op in {0,1,2,3,6,7,8,9}:
  - result computed into shadow registers
  - counter loaded with MUL_CYCLES or DIV_CYCLES; busy=1 from that edge
- Latency: busy stays high for exactly N cycles (N = class latency).
  - On the Nth edge after accept: shadow copied to hi/lo, busy=0, done=1 for one cycle.
  - Back-to-back: a new start may be accepted on the cycle busy is low, including the cycle done is high.
- Start while busy=1 is ignored; no queuing. start with op in {4,5,10-15} is ignored.
- mthi/mtlo:
  - When busy=0 and flush=0: op=4 writes hi<=src_a, op=5 writes lo<=src_a, regardless of start. Single cycle; busy and done are not asserted.
  - Ignored when busy=1.
- Arithmetic:
  - mult: signed WIDTH×WIDTH -> 2·WIDTH product; {hi,lo}.
  - multu: unsigned product; {hi,lo}.
  - madd/maddu: {hi,lo} + product (signed/unsigned product); 2·WIDTH sum wraps modulo 2^(2·WIDTH).
  - msub/msubu: {hi,lo} − product, same wrap rule.
  - Accumulate ops read the committed hi/lo at the accept edge (always final, since busy=0).
  - div: lo = quotient truncated toward zero; hi = remainder with sign of dividend.
  - div overflow (src_a = most-negative, src_b = −1): lo = most-negative, hi = 0.
  - divu: unsigned quotient/remainder.
  - Divide by zero: the op is accepted, busy runs the full DIV_CYCLES, and the commit leaves hi/lo unchanged. done still pulses.
- Flush:
  - When busy=1, flush aborts the op: busy=0 and counter=0 on the next edge; hi/lo keep pre-op values; no done pulse.
  - Flush on the same edge as a would-be commit wins: no commit.
  - Flush with start (busy=0): start dropped.
  - Flush with op=4/5 (busy=0): write dropped.
- Counter is $clog2(max(MUL_CYCLES,DIV_CYCLES)+1) bits wide; it never underflows and holds 0 when idle.
- No combinational path from the inputs to any output; all outputs are registered.

Test Plan:
- Reset, then mult with src_a=0xFFFFFFFE (−2), src_b=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- multu with 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Preload via mthi 0, mtlo 10; madd 3×4 -> lo=22. Then msubu 5×5 -> {hi,lo}=0xFFFFFFFF_FFFFFFFD.
- Div cases:
  - div −7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
  - div 0x80000000/−1 -> lo=0x80000000, hi=0.
  - divu x/0 -> hi/lo unchanged, done pulses.
- Start div; assert flush on busy cycle 4 -> busy low next cycle, hi/lo unchanged, no done. Start asserted during busy is ignored, with the completion cycle count unchanged.
- Parameterisation: WIDTH=16, MUL_CYCLES=1 -> mult 0x8000×0x8000 commits on the first edge after accept with hi=0x4000, lo=0x0000. Reset asserted mid-divide -> all outputs 0 next edge.
